parse_unit: RTL and testbench
=============================

Name: parse_unit

Overview:
- Stage 1 of the front end; sits directly downstream of the L1 instruction cache / fetch stage.
- Each cycle it receives one 60-bit bundle of two 30-bit instructions, tagged with its PC.
- It splits the bundle into slot 0 (bits 59:30) and slot 1 (bits 29:0), drops all-zero NOPs, decodes fields and buffers the instructions in a small queue.
- Decode consumes the queue one instruction per cycle under a valid/ready handshake.

Parameters:
- QUEUE_DEPTH, 8, instruction queue entries; power of two, at least 4.
- DROP_NOPS, 1, 1 = all-zero instructions are not enqueued; 0 = NOPs are enqueued like any other instruction.

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  bundle valid from fetch.
- PC_i  in  16  PC of the incoming bundle.
- bundle_i  in  60  slot0 = [59:30], slot1 = [29:0].
- flush_i  in  1  branch redirect: discard queue contents and any same-cycle bundle.
- ready_i  in  1  decode accepts the head instruction.
- valid_o  out  1  head instruction present.
- instr_o  out  30  raw head instruction.
- format_o  out  1  instr[29]; 1 = reg-imm, 0 = reg-reg.
- branch_o  out  1  instr[28].
- opcode_o  out  7  instr[27:21].
- rd_o  out  5  primary operand, instr[20:16].
- rs_o  out  5  secondary register, instr[15:11]; zero when format = 1.
- imm_o  out  16  instr[15:0] when format = 1; zero when format = 0.
- PC_o  out  16  PC of the bundle the head came from.
- slot_o  out  1  0 = upper half of bundle, 1 = lower half.
- count_o  out  clog2(QUEUE_DEPTH)+1  current occupancy.
- full_o  out  1  free entries < 2.
- overflow_o  out  1  sticky: a bundle was dropped for lack of space.

Behaviour:
- Reset (reset_i low, asynchronous): read pointer, write pointer and count go to 0; overflow_o = 0. Hence valid_o = 0, full_o = 0, and all field outputs read 0. Contents of queue storage are don't-care.
- Field outputs are combinational from the queue head (first-word fall-through). They are forced to 0 when valid_o = 0.
- Latency: bundle sampled at rising edge N; its first surviving instruction appears on valid_o after edge N.
- Enqueue at each edge when enable_i = 1 and flush_i = 0:
  - Survivors are the non-NOP slots. A slot is a NOP when all 30 bits are 0, and only when DROP_NOPS = 1.
  - 0, 1 or 2 entries are written. Slot 0 is always written before slot 1.
  - Each entry stores {instr, PC_i, slot}.
- Dequeue at each edge when valid_o = 1 and ready_i = 1; the head advances by one.
- Acceptance is decided on the pre-edge count: the bundle is accepted only when QUEUE_DEPTH - count >= 2.
  - A same-cycle dequeue does not create space for that cycle's bundle.
  - A rejected bundle is discarded whole and sets overflow_o = 1, which holds until reset.
  - A bundle with zero survivors is never rejected.
- Simultaneous enqueue and dequeue: count_next = count + survivors - pop.
- full_o = (QUEUE_DEPTH - count < 2), combinational from count. Upstream is required to withhold enable_i while full_o = 1.
- flush_i = 1 at an edge: pointers and count go to 0, the same-cycle bundle is dropped, and no pop is counted. flush_i has priority over enqueue and dequeue. overflow_o is unaffected.
- Pointers wrap modulo QUEUE_DEPTH. The second write uses wptr + 1 modulo depth.
- Field extraction:
  - rs_o = instr[15:11] only when format = 0.
  - imm_o = instr[15:0] only when format = 1.
  - The unused field reads 0.
- No reset of queue storage is required.

Decomposition:
- Package parse_pkg:
  - bit-position and width constants: FMT_BIT = 29, BR_BIT = 28, OPC_MSB/LSB = 27/21, RD_MSB/LSB = 20/16, RS_MSB/LSB = 15/11, IMM_WIDTH = 16, INSTR_WIDTH = 30, BUNDLE_WIDTH = 60, PC_WIDTH = 16;
  - NOP_INSTR constant (all zero);
  - packed entry typedef {instr, pc, slot}.
- Sub-module instr_queue: circular FIFO with two write ports, one read port and a flush input, parameterised on depth.
- parse_unit itself holds the bundle split, NOP filter, acceptance check, field decode and overflow flag.

Test Plan:
1. Reset, then one bundle with PC = 3, slot0 = 0_0_0000010_00001_00010_00000000000, slot1 = 0, ready_i = 0 -> after the edge: count_o = 1, valid_o = 1, opcode_o = 0000010, rd_o = 1, rs_o = 2, format_o = 0, imm_o = 0, PC_o = 3, slot_o = 0.
2. Bundle with PC = 1 carrying two reg-imm loads (opcode 0001010, rd 1 imm 5; rd 2 imm 10), ready_i = 1 -> consecutive heads: {rd 1, imm 5, slot 0, PC 1} then {rd 2, imm 10, slot 1, PC 1}; count_o returns to 0 and valid_o = 0.
3. ready_i = 0, QUEUE_DEPTH = 8, four full two-instruction bundles -> count_o = 8, full_o = 1 from count 7 onward; a fifth bundle -> dropped, count_o stays 8, overflow_o = 1 and stays 1 after draining.
4. count_o = 6, ready_i = 1, two-instruction bundle -> accepted, count_o = 7. Then at count 7 another bundle with ready_i = 1 -> rejected, count_o = 6, overflow_o = 1.
5. count_o = 5 with flush_i = 1 plus a same-cycle valid bundle -> count_o = 0, valid_o = 0 after the edge; the next bundle enqueues normally at pointer position 0.
6. reset_i driven low between clock edges with count_o = 4 -> valid_o, count_o and overflow_o go to 0 immediately, before the next edge. With DROP_NOPS = 0, an all-NOP bundle then yields count_o = 2.

Source files
------------

// File: rtl/parse_pkg.sv
// Shared constants and types for the instruction parse stage: bit positions
// of the instruction fields and the layout of one queue entry.
package parse_pkg;

   localparam int INSTR_WIDTH  = 30;
   localparam int BUNDLE_WIDTH = 60;
   localparam int PC_WIDTH     = 16;

   localparam int FMT_BIT   = 29;
   localparam int BR_BIT    = 28;
   localparam int OPC_MSB   = 27;
   localparam int OPC_LSB   = 21;
   localparam int RD_MSB    = 20;
   localparam int RD_LSB    = 16;
   localparam int RS_MSB    = 15;
   localparam int RS_LSB    = 11;
   localparam int IMM_WIDTH = 16;

   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = '0;

   // One buffered instruction together with where it came from.
   typedef struct packed {
      logic [INSTR_WIDTH-1:0] instr;
      logic [PC_WIDTH-1:0]    pc;
      logic                   slot;
   } entry_t;

   function automatic logic is_nop(input logic [INSTR_WIDTH-1:0] instr);
      return instr == NOP_INSTR;
   endfunction

endpackage

// File: rtl/instr_queue.sv
// Circular instruction FIFO: two write ports (first/second survivor of a
// bundle, written to consecutive locations), one first-word-fall-through
// read port and a flush that empties the queue in one cycle.
module instr_queue
   import parse_pkg::*;
#(
   parameter int  DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             flush,
   input  logic             push_first,
   input  entry_t           first_data,
   input  logic             push_second,
   input  entry_t           second_data,
   input  logic             pop,
   output entry_t           head,
   output logic [CNT_W-1:0] count
);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wptr_reg, wptr_next;
   logic [PTR_W-1:0] rptr_reg, rptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [1:0]       push_num;

   assign push_num = {1'b0, push_first} + {1'b0, push_second};

   // Storage is never reset; the second entry lands one slot after the first.
   always_ff @(posedge clock_i) begin
      if (!flush) begin
         if (push_first) begin
            mem[wptr_reg] <= first_data;
         end
         if (push_second) begin
            mem[wptr_reg + PTR_W'(1)] <= second_data;
         end
      end
   end

   // Pointer and occupancy bookkeeping; flush wins over push and pop.
   always_comb begin
      wptr_next  = wptr_reg;
      rptr_next  = rptr_reg;
      count_next = count_reg;
      if (flush) begin
         wptr_next  = '0;
         rptr_next  = '0;
         count_next = '0;
      end else begin
         wptr_next  = wptr_reg + PTR_W'(push_num);
         if (pop) begin
            rptr_next = rptr_reg + PTR_W'(1);
         end
         count_next = count_reg + CNT_W'(push_num) - CNT_W'(pop);
      end
   end

   // Pointer/count registers with asynchronous active-low reset.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         count_reg <= '0;
      end else begin
         wptr_reg  <= wptr_next;
         rptr_reg  <= rptr_next;
         count_reg <= count_next;
      end
   end

   assign head  = mem[rptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/parse_unit.sv
// Front-end parse stage: splits each fetched bundle into two instructions,
// filters NOPs, buffers survivors and presents the decoded queue head.
module parse_unit
   import parse_pkg::*;
#(
   parameter int  QUEUE_DEPTH = 8,
   parameter bit  DROP_NOPS   = 1'b1,
   localparam int CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic                       enable_i,
   input  logic [PC_WIDTH-1:0]        PC_i,
   input  logic [BUNDLE_WIDTH-1:0]    bundle_i,
   input  logic                       flush_i,
   input  logic                       ready_i,
   output logic                       valid_o,
   output logic [INSTR_WIDTH-1:0]     instr_o,
   output logic                       format_o,
   output logic                       branch_o,
   output logic [OPC_MSB-OPC_LSB:0]   opcode_o,
   output logic [RD_MSB-RD_LSB:0]     rd_o,
   output logic [RS_MSB-RS_LSB:0]     rs_o,
   output logic [IMM_WIDTH-1:0]       imm_o,
   output logic [PC_WIDTH-1:0]        PC_o,
   output logic                       slot_o,
   output logic [CNT_W-1:0]           count_o,
   output logic                       full_o,
   output logic                       overflow_o
);

   entry_t           slot_entry [2];
   logic [1:0]       slot_keep;
   logic             any_survivor;
   logic             space_ok;
   logic             accept;
   logic             reject;
   logic             push_first;
   logic             push_second;
   entry_t           first_data;
   entry_t           head;
   logic [CNT_W-1:0] count_w;
   logic [CNT_W-1:0] free_entries;
   logic             overflow_reg, overflow_next;

   // Slot 0 is the upper half of the bundle, slot 1 the lower half.
   for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      assign slot_entry[gi] = '{
         instr: bundle_i[BUNDLE_WIDTH-1-gi*INSTR_WIDTH -: INSTR_WIDTH],
         pc:    PC_i,
         slot:  1'(gi)
      };
      assign slot_keep[gi] = !(DROP_NOPS && is_nop(slot_entry[gi].instr));
   end

   // Space is judged on the pre-edge count only; a same-cycle pop does not help.
   assign free_entries = CNT_W'(QUEUE_DEPTH) - count_w;
   assign space_ok     = free_entries >= CNT_W'(2);
   assign full_o       = !space_ok;
   assign any_survivor = |slot_keep;
   assign accept       = enable_i && !flush_i && any_survivor && space_ok;
   assign reject       = enable_i && !flush_i && any_survivor && !space_ok;

   // Compact survivors so a lone survivor always uses the first write port.
   always_comb begin
      push_first  = accept;
      push_second = accept && slot_keep[0] && slot_keep[1];
      first_data  = slot_keep[0] ? slot_entry[0] : slot_entry[1];
   end

   instr_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .flush       (flush_i),
      .push_first  (push_first),
      .first_data  (first_data),
      .push_second (push_second),
      .second_data (slot_entry[1]),
      .pop         (valid_o && ready_i),
      .head        (head),
      .count       (count_w)
   );

   assign count_o = count_w;
   assign valid_o = count_w != '0;

   // Sticky overflow: set by any discarded bundle, cleared only by reset.
   always_comb begin
      overflow_next = overflow_reg | reject;
   end

   // Overflow flag register.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         overflow_reg <= 1'b0;
      end else begin
         overflow_reg <= overflow_next;
      end
   end

   assign overflow_o = overflow_reg;

   // Head field decode; everything reads zero when the queue is empty.
   always_comb begin
      instr_o  = '0;
      format_o = 1'b0;
      branch_o = 1'b0;
      opcode_o = '0;
      rd_o     = '0;
      rs_o     = '0;
      imm_o    = '0;
      PC_o     = '0;
      slot_o   = 1'b0;
      if (valid_o) begin
         instr_o  = head.instr;
         format_o = head.instr[FMT_BIT];
         branch_o = head.instr[BR_BIT];
         opcode_o = head.instr[OPC_MSB:OPC_LSB];
         rd_o     = head.instr[RD_MSB:RD_LSB];
         PC_o     = head.pc;
         slot_o   = head.slot;
         if (head.instr[FMT_BIT]) begin
            imm_o = head.instr[IMM_WIDTH-1:0];
         end else begin
            rs_o = head.instr[RS_MSB:RS_LSB];
         end
      end
   end

endmodule

// File: tb/tb_parse_unit.sv
// Self-checking bench for parse_unit: one instance drops NOPs, a second keeps
// them; both are checked against a queue-based reference model each cycle.
module tb_parse_unit;

   localparam int DEPTH = 8;

   typedef struct packed {
      logic [29:0] instr;
      logic [15:0] pc;
      logic        slot;
   } m_entry_t;

   typedef struct packed {
      logic        valid;
      logic [29:0] instr;
      logic        fmt;
      logic        br;
      logic [6:0]  opc;
      logic [4:0]  rd;
      logic [4:0]  rs;
      logic [15:0] imm;
      logic [15:0] pc;
      logic        slot;
      logic [3:0]  count;
      logic        full;
      logic        ovf;
   } obs_t;

   typedef struct packed {
      logic        en;
      logic [15:0] pc;
      logic [29:0] s0;
      logic [29:0] s1;
      logic        rdy;
      logic        exp_valid;
      logic [3:0]  exp_count;
      logic        exp_full;
      logic        exp_ovf;
      logic [29:0] exp_instr;
      logic [15:0] exp_pc;
      logic        exp_slot;
   } vec_t;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        enable_i = 1'b0;
   logic [15:0] PC_i = '0;
   logic [59:0] bundle_i = '0;
   logic        flush_i = 1'b0;
   logic        ready_i = 1'b0;

   logic        a_valid, a_fmt, a_br, a_slot, a_full, a_ovf;
   logic [29:0] a_instr;
   logic [6:0]  a_opc;
   logic [4:0]  a_rd, a_rs;
   logic [15:0] a_imm, a_pc;
   logic [3:0]  a_count;
   logic        b_valid, b_fmt, b_br, b_slot, b_full, b_ovf;
   logic [29:0] b_instr;
   logic [6:0]  b_opc;
   logic [4:0]  b_rd, b_rs;
   logic [15:0] b_imm, b_pc;
   logic [3:0]  b_count;

   obs_t obs_a, obs_b;

   int n_checks = 0;
   int n_errors = 0;

   m_entry_t mq_a[$];
   m_entry_t mq_b[$];
   bit       movf_a = 1'b0;
   bit       movf_b = 1'b0;

   vec_t vt [10];

   always #5 clock_i = ~clock_i;

   parse_unit #(.QUEUE_DEPTH(DEPTH), .DROP_NOPS(1'b1)) dut_a (
      .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .PC_i(PC_i),
      .bundle_i(bundle_i), .flush_i(flush_i), .ready_i(ready_i),
      .valid_o(a_valid), .instr_o(a_instr), .format_o(a_fmt), .branch_o(a_br),
      .opcode_o(a_opc), .rd_o(a_rd), .rs_o(a_rs), .imm_o(a_imm), .PC_o(a_pc),
      .slot_o(a_slot), .count_o(a_count), .full_o(a_full), .overflow_o(a_ovf)
   );

   parse_unit #(.QUEUE_DEPTH(DEPTH), .DROP_NOPS(1'b0)) dut_b (
      .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .PC_i(PC_i),
      .bundle_i(bundle_i), .flush_i(flush_i), .ready_i(ready_i),
      .valid_o(b_valid), .instr_o(b_instr), .format_o(b_fmt), .branch_o(b_br),
      .opcode_o(b_opc), .rd_o(b_rd), .rs_o(b_rs), .imm_o(b_imm), .PC_o(b_pc),
      .slot_o(b_slot), .count_o(b_count), .full_o(b_full), .overflow_o(b_ovf)
   );

   always_comb begin
      obs_a = '{a_valid, a_instr, a_fmt, a_br, a_opc, a_rd, a_rs, a_imm, a_pc,
                a_slot, a_count, a_full, a_ovf};
      obs_b = '{b_valid, b_instr, b_fmt, b_br, b_opc, b_rd, b_rs, b_imm, b_pc,
                b_slot, b_count, b_full, b_ovf};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a plain queue updated from the bundle rules.
   task automatic model_update(input int k, input logic en, input logic fl,
                               input logic rdy, input logic [15:0] pc,
                               input logic [59:0] b);
      m_entry_t q[$];
      m_entry_t surv[$];
      bit          drop;
      bit          ov;
      int          sz;
      logic [29:0] ins;
      if (k == 0) begin q = mq_a; drop = 1'b1; ov = movf_a; end
      else        begin q = mq_b; drop = 1'b0; ov = movf_b; end
      if (fl) begin
         q.delete();
      end else begin
         sz = q.size();
         for (int s = 0; s < 2; s++) begin
            ins = (s == 0) ? b[59:30] : b[29:0];
            if (!(drop && ins == 30'h0)) surv.push_back('{ins, pc, s[0]});
         end
         if (sz > 0 && rdy) void'(q.pop_front());
         if (en && surv.size() > 0) begin
            if (DEPTH - sz >= 2) begin
               for (int j = 0; j < surv.size(); j++) q.push_back(surv[j]);
            end else begin
               ov = 1'b1;
            end
         end
      end
      if (k == 0) begin mq_a = q; movf_a = ov; end
      else        begin mq_b = q; movf_b = ov; end
   endtask

   task automatic check_model(input int k);
      obs_t     o;
      m_entry_t q[$];
      m_entry_t h;
      bit       ov;
      string    t;
      if (k == 0) begin o = obs_a; q = mq_a; ov = movf_a; t = "A"; end
      else        begin o = obs_b; q = mq_b; ov = movf_b; t = "B"; end
      h = '0;
      if (q.size() > 0) h = q[0];
      chk({t, " valid"}, 32'(o.valid), 32'(q.size() != 0));
      chk({t, " count"}, 32'(o.count), 32'(q.size()));
      chk({t, " full"},  32'(o.full),  32'((DEPTH - q.size()) < 2));
      chk({t, " ovf"},   32'(o.ovf),   32'(ov));
      chk({t, " instr"}, 32'(o.instr), 32'(h.instr));
      chk({t, " pc"},    32'(o.pc),    32'(h.pc));
      chk({t, " slot"},  32'(o.slot),  32'(h.slot));
      chk({t, " fmt"},   32'(o.fmt),   32'(h.instr[29]));
      chk({t, " br"},    32'(o.br),    32'(h.instr[28]));
      chk({t, " opc"},   32'(o.opc),   32'(h.instr[27:21]));
      chk({t, " rd"},    32'(o.rd),    32'(h.instr[20:16]));
      chk({t, " rs"},    32'(o.rs),    h.instr[29] ? 32'h0 : 32'(h.instr[15:11]));
      chk({t, " imm"},   32'(o.imm),   h.instr[29] ? 32'(h.instr[15:0]) : 32'h0);
   endtask

   // One clock: drive inputs, let the edge happen, update model, compare.
   task automatic step(input logic en, input logic [15:0] pc, input logic [29:0] s0,
                       input logic [29:0] s1, input logic fl, input logic rdy);
      enable_i = en; PC_i = pc; bundle_i = {s0, s1}; flush_i = fl; ready_i = rdy;
      @(posedge clock_i);
      model_update(0, en, fl, rdy, pc, {s0, s1});
      model_update(1, en, fl, rdy, pc, {s0, s1});
      @(negedge clock_i);
      check_model(0);
      check_model(1);
      enable_i = 1'b0; flush_i = 1'b0;
      $display("step en=%0b pc=%0h b=%015h fl=%0b rdy=%0b -> cntA=%0d cntB=%0d ovfA=%0b",
               en, pc, {s0, s1}, fl, rdy, a_count, b_count, a_ovf);
   endtask

   task automatic do_reset();
      reset_i = 1'b0;
      mq_a.delete(); mq_b.delete(); movf_a = 1'b0; movf_b = 1'b0;
      @(posedge clock_i);
      @(negedge clock_i);
      reset_i = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [29:0] ia, l1, l2;
      logic [29:0] s0, s1;
      ia = 30'h00411000;   // reg-reg opc 2 rd 1 rs 2
      l1 = 30'h21410005;   // reg-imm opc 10 rd 1 imm 5
      l2 = 30'h2142000A;   // reg-imm opc 10 rd 2 imm 10

      //        en pc      s0            s1            rdy v  cnt f  o  instr         pc      sl
      vt[0] = '{1, 16'h3,  ia,           30'h0,        0,  1, 1,  0, 0, ia,           16'h3,  0};
      vt[1] = '{0, 16'h0,  30'h0,        30'h0,        1,  0, 0,  0, 0, 30'h0,        16'h0,  0};
      vt[2] = '{1, 16'h1,  l1,           l2,           1,  1, 2,  0, 0, l1,           16'h1,  0};
      vt[3] = '{0, 16'h0,  30'h0,        30'h0,        1,  1, 1,  0, 0, l2,           16'h1,  1};
      vt[4] = '{0, 16'h0,  30'h0,        30'h0,        1,  0, 0,  0, 0, 30'h0,        16'h0,  0};
      vt[5] = '{1, 16'h10, 30'h00001001, 30'h00001002, 0,  1, 2,  0, 0, 30'h00001001, 16'h10, 0};
      vt[6] = '{1, 16'h11, 30'h00001011, 30'h00001012, 0,  1, 4,  0, 0, 30'h00001001, 16'h10, 0};
      vt[7] = '{1, 16'h12, 30'h00001021, 30'h00001022, 0,  1, 6,  0, 0, 30'h00001001, 16'h10, 0};
      vt[8] = '{1, 16'h13, 30'h00001031, 30'h00001032, 0,  1, 8,  1, 0, 30'h00001001, 16'h10, 0};
      vt[9] = '{1, 16'h14, 30'h00001041, 30'h00001042, 0,  1, 8,  1, 1, 30'h00001001, 16'h10, 0};

      // Reset state.
      @(negedge clock_i);
      chk("rst valid", 32'(a_valid), 32'h0);
      chk("rst count", 32'(a_count), 32'h0);
      chk("rst full",  32'(a_full),  32'h0);
      chk("rst ovf",   32'(a_ovf),   32'h0);
      chk("rst instr", 32'(a_instr), 32'h0);
      do_reset();

      // Table vectors: single bundle, FWFT drain, fill to overflow.
      for (int i = 0; i < 10; i++) begin
         step(vt[i].en, vt[i].pc, vt[i].s0, vt[i].s1, 1'b0, vt[i].rdy);
         chk($sformatf("vec%0d valid", i), 32'(a_valid), 32'(vt[i].exp_valid));
         chk($sformatf("vec%0d count", i), 32'(a_count), 32'(vt[i].exp_count));
         chk($sformatf("vec%0d full", i),  32'(a_full),  32'(vt[i].exp_full));
         chk($sformatf("vec%0d ovf", i),   32'(a_ovf),   32'(vt[i].exp_ovf));
         chk($sformatf("vec%0d instr", i), 32'(a_instr), 32'(vt[i].exp_instr));
         chk($sformatf("vec%0d pc", i),    32'(a_pc),    32'(vt[i].exp_pc));
         chk($sformatf("vec%0d slot", i),  32'(a_slot),  32'(vt[i].exp_slot));
         if (i == 0) begin
            chk("t1 opcode", 32'(a_opc), 32'h2);
            chk("t1 rd",     32'(a_rd),  32'h1);
            chk("t1 rs",     32'(a_rs),  32'h2);
            chk("t1 fmt",    32'(a_fmt), 32'h0);
            chk("t1 imm",    32'(a_imm), 32'h0);
         end
         if (i == 2 || i == 3) begin
            chk("t2 opcode", 32'(a_opc), 32'hA);
            chk("t2 fmt",    32'(a_fmt), 32'h1);
            chk("t2 rs",     32'(a_rs),  32'h0);
            chk("t2 rd",     32'(a_rd),  (i == 2) ? 32'h1 : 32'h2);
            chk("t2 imm",    32'(a_imm), (i == 2) ? 32'h5 : 32'hA);
         end
      end
      for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 30'h0, 30'h0, 1'b0, 1'b1);
      chk("t3 drained count", 32'(a_count), 32'h0);
      chk("t3 drained ovf",   32'(a_ovf),   32'h1);

      // Boundary at count 6 and 7 with a concurrent pop.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 16'h20, 30'h100 + 30'(i), 30'h200 + 30'(i), 1'b0, 1'b0);
      step(1'b1, 16'h21, 30'h301, 30'h302, 1'b0, 1'b1);
      chk("t4 accept count", 32'(a_count), 32'h7);
      chk("t4 accept ovf",   32'(a_ovf),   32'h0);
      step(1'b1, 16'h22, 30'h401, 30'h402, 1'b0, 1'b1);
      chk("t4 reject count", 32'(a_count), 32'h6);
      chk("t4 reject ovf",   32'(a_ovf),   32'h1);

      // Asynchronous reset between edges at count 4.
      step(1'b0, 16'h0, 30'h0, 30'h0, 1'b0, 1'b1);
      step(1'b0, 16'h0, 30'h0, 30'h0, 1'b0, 1'b1);
      chk("t6 pre count", 32'(a_count), 32'h4);
      #2;
      reset_i = 1'b0;
      #1;
      chk("t6 async valid", 32'(a_valid), 32'h0);
      chk("t6 async count", 32'(a_count), 32'h0);
      chk("t6 async ovf",   32'(a_ovf),   32'h0);
      mq_a.delete(); mq_b.delete(); movf_a = 1'b0; movf_b = 1'b0;
      @(negedge clock_i);
      reset_i = 1'b1;
      step(1'b1, 16'h30, 30'h0, 30'h0, 1'b0, 1'b0);
      chk("t6 nop drop count", 32'(a_count), 32'h0);
      chk("t6 nop keep count", 32'(b_count), 32'h2);

      // Flush with a same-cycle bundle, then refill from position 0.
      do_reset();
      step(1'b1, 16'h40, 30'h501, 30'h502, 1'b0, 1'b0);
      step(1'b1, 16'h41, 30'h511, 30'h512, 1'b0, 1'b0);
      step(1'b1, 16'h42, 30'h521, 30'h0,   1'b0, 1'b0);
      chk("t5 pre count", 32'(a_count), 32'h5);
      step(1'b1, 16'h43, 30'h531, 30'h532, 1'b1, 1'b1);
      chk("t5 flush count", 32'(a_count), 32'h0);
      chk("t5 flush valid", 32'(a_valid), 32'h0);
      step(1'b1, 16'h55, ia, l1, 1'b0, 1'b0);
      chk("t5 refill count", 32'(a_count), 32'h2);
      chk("t5 refill instr", 32'(a_instr), 32'(ia));
      chk("t5 refill pc",    32'(a_pc),    32'h55);

      // Randomised traffic against the model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         s0 = ($urandom_range(3) == 0) ? 30'h0 : 30'($urandom);
         s1 = ($urandom_range(3) == 0) ? 30'h0 : 30'($urandom);
         step($urandom_range(9) < 6, 16'($urandom), s0, s1,
              $urandom_range(19) == 0, $urandom_range(1) == 1);
         if ($urandom_range(99) == 0) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
